// File: rtl/muldiv_iter_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package muldiv_iter_pkg;

  // M-extension operation, encoded in funct3 order
  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } mdop_t;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StMul  = 3'd1,
    StDiv  = 3'd2,
    StFix  = 3'd3,
    StDone = 3'd4
  } mdstate_t;

  function automatic logic md_is_div(mdop_t op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Request/response handshake bundle between the execute stage and the mul/div unit.
interface muldiv_iter_if #(
  parameter int unsigned XLEN = 32
) ();
  import muldiv_iter_pkg::*;

  logic            req_valid;
  logic            req_ready;
  mdop_t           req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result
  );

endinterface

// File: rtl/muldiv_divstep.sv
// Combinational restoring-divide slice: shifts DIV_STEP dividend bits into the
// partial remainder and produces DIV_STEP quotient bits, MSB first.
module muldiv_divstep #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DIV_STEP = 1
) (
  input  logic [XLEN-1:0]     rem_in,
  input  logic [XLEN-1:0]     divisor,
  input  logic [DIV_STEP-1:0] dividend_bits,
  output logic [XLEN-1:0]     rem_out,
  output logic [DIV_STEP-1:0] quot_bits
);

  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem;

  // Partial remainder stays below the divisor, so each trial fits in XLEN+1 bits
  always_comb begin
    trial     = '0;
    rem       = rem_in;
    quot_bits = '0;
    for (int i = DIV_STEP - 1; i >= 0; i--) begin
      trial = {rem, dividend_bits[i]};
      if (trial >= {1'b0, divisor}) begin
        trial        = trial - {1'b0, divisor};
        quot_bits[i] = 1'b1;
      end
      rem = trial[XLEN-1:0];
    end
    rem_out = rem;
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit with sign fixup, divide special cases,
// kill abort and a result-holding valid/ready handshake.
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 4,
  parameter int unsigned DIV_STEP = 1
) (
  input  logic         clk_core,
  input  logic         reset_n,
  muldiv_iter_if.slave bus,
  input  logic         kill,
  output logic         busy
);

  localparam int unsigned PW       = 2 * XLEN;
  localparam int unsigned SumW     = XLEN + MUL_STEP;
  localparam int unsigned MulIters = XLEN / MUL_STEP;
  localparam int unsigned DivIters = XLEN / DIV_STEP;
  localparam int unsigned CntW     = $clog2(XLEN + 1);
  localparam logic [CntW-1:0] MulLast = CntW'(MulIters - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(DivIters - 1);

  mdstate_t        state_q;
  mdop_t           op_q;
  logic            neg_q;
  logic [XLEN-1:0] dsor_q;
  logic [XLEN-1:0] result_q;
  logic [PW-1:0]   acc_q;
  logic [CntW-1:0] cnt_q;

  logic            accept;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic            start_neg, start_special;
  logic [XLEN-1:0] start_result, start_dsor;
  logic [PW-1:0]   start_acc;
  mdstate_t        start_state;

  assign bus.req_ready   = (state_q == StIdle) | ((state_q == StDone) & bus.resp_ready);
  assign bus.resp_valid  = (state_q == StDone);
  assign bus.resp_result = result_q;
  assign busy            = (state_q != StIdle);
  assign accept          = bus.req_valid & bus.req_ready & ~kill;

  // Entry decode: operand magnitudes, negate flag and the short-circuit divide cases
  always_comb begin
    a_neg = (bus.req_op inside {OpMulh, OpMulhsu, OpDiv, OpRem}) & bus.req_a[XLEN-1];
    b_neg = (bus.req_op inside {OpMulh, OpDiv, OpRem}) & bus.req_b[XLEN-1];
    a_mag = a_neg ? (~bus.req_a + 1'b1) : bus.req_a;
    b_mag = b_neg ? (~bus.req_b + 1'b1) : bus.req_b;

    case (bus.req_op)
      OpMulh, OpDiv:   start_neg = a_neg ^ b_neg;
      OpMulhsu, OpRem: start_neg = a_neg;
      default:         start_neg = 1'b0;
    endcase

    div_zero = md_is_div(bus.req_op) && (bus.req_b == '0);
    div_ovf  = (bus.req_op inside {OpDiv, OpRem}) &&
               (bus.req_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.req_b == '1);
    start_special = div_zero | div_ovf;

    start_result = '0;
    if (div_zero) begin
      start_result = (bus.req_op inside {OpDiv, OpDivu}) ? '1 : bus.req_a;
    end else if (div_ovf) begin
      start_result = (bus.req_op == OpDiv) ? bus.req_a : '0;
    end

    // Multiply keeps the multiplier in the low half; divide keeps the dividend there
    if (md_is_div(bus.req_op)) begin
      start_acc  = {{XLEN{1'b0}}, a_mag};
      start_dsor = b_mag;
    end else begin
      start_acc  = {{XLEN{1'b0}}, b_mag};
      start_dsor = a_mag;
    end

    if (start_special) begin
      start_state = StDone;
    end else if (md_is_div(bus.req_op)) begin
      start_state = StDiv;
    end else begin
      start_state = StMul;
    end
  end

  // Multiply step: add multiplicand x next digit into the high half, then shift right
  logic [MUL_STEP-1:0] mul_digit;
  logic [SumW-1:0]     mul_sum;
  logic [PW-1:0]       mul_next;

  always_comb begin
    mul_digit = acc_q[MUL_STEP-1:0];
    mul_sum   = SumW'(acc_q[PW-1:XLEN]) + SumW'(dsor_q) * SumW'(mul_digit);
    mul_next  = {mul_sum, acc_q[XLEN-1:MUL_STEP]};
  end

  // Divide step: remainder lives in the high half, quotient bits shift into the low half
  logic [XLEN-1:0]     div_rem;
  logic [DIV_STEP-1:0] div_quot;
  logic [PW-1:0]       div_next;

  muldiv_divstep #(
    .XLEN    (XLEN),
    .DIV_STEP(DIV_STEP)
  ) u_divstep (
    .rem_in       (acc_q[PW-1:XLEN]),
    .divisor      (dsor_q),
    .dividend_bits(acc_q[XLEN-1 -: DIV_STEP]),
    .rem_out      (div_rem),
    .quot_bits    (div_quot)
  );

  assign div_next = {div_rem, acc_q[XLEN-DIV_STEP-1:0], div_quot};

  // Sign fixup and result-word selection
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, fix_result;

  always_comb begin
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? (~acc_q[PW-1:XLEN] + 1'b1) : acc_q[PW-1:XLEN];
    case (op_q)
      OpMul:                     fix_result = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fix_result = prod_fix[PW-1:XLEN];
      OpDiv, OpDivu:             fix_result = quot_fix;
      default:                   fix_result = rem_fix;
    endcase
  end

  // Control FSM and datapath registers; kill wins over accept and resp_ready
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      neg_q    <= 1'b0;
      dsor_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (kill) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else if (accept) begin
      state_q <= start_state;
      op_q    <= bus.req_op;
      neg_q   <= start_neg;
      dsor_q  <= start_dsor;
      acc_q   <= start_acc;
      cnt_q   <= '0;
      if (start_special) begin
        result_q <= start_result;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StMul: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == MulLast) begin
            state_q <= StFix;
          end
        end
        StDiv: begin
          acc_q <= div_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == DivLast) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          result_q <= fix_result;
          state_q  <= StDone;
        end
        StDone: begin
          if (bus.resp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifndef SYNTHESIS
  // The requester must hold req_valid for the whole operation unless it kills it
  assert property (@(posedge clk_core) disable iff (!reset_n)
    ((state_q inside {StMul, StDiv, StFix}) && !kill) |-> bus.req_valid);
`endif

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed and randomised checks of muldiv_iter across three step configurations
// driven in lock-step with a shared operand bus.
module tb_muldiv_iter;
  import muldiv_iter_pkg::*;

  localparam int unsigned MS [3] = '{4, 8, 1};
  localparam int unsigned DS [3] = '{1, 2, 2};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        kill;
  mdop_t       op;
  logic [31:0] a, b;
  logic [2:0]  rv, rr, vld, bsy, rdy;
  logic [31:0] res [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_iter_if #(.XLEN(32)) bus0 ();
  muldiv_iter_if #(.XLEN(32)) bus1 ();
  muldiv_iter_if #(.XLEN(32)) bus2 ();

  assign bus0.req_valid = rv[0];
  assign bus0.req_op    = op;
  assign bus0.req_a     = a;
  assign bus0.req_b     = b;
  assign bus0.resp_ready = rr[0];
  assign vld[0] = bus0.resp_valid;
  assign rdy[0] = bus0.req_ready;
  assign res[0] = bus0.resp_result;

  assign bus1.req_valid = rv[1];
  assign bus1.req_op    = op;
  assign bus1.req_a     = a;
  assign bus1.req_b     = b;
  assign bus1.resp_ready = rr[1];
  assign vld[1] = bus1.resp_valid;
  assign rdy[1] = bus1.req_ready;
  assign res[1] = bus1.resp_result;

  assign bus2.req_valid = rv[2];
  assign bus2.req_op    = op;
  assign bus2.req_a     = a;
  assign bus2.req_b     = b;
  assign bus2.resp_ready = rr[2];
  assign vld[2] = bus2.resp_valid;
  assign rdy[2] = bus2.req_ready;
  assign res[2] = bus2.resp_result;

  muldiv_iter #(.XLEN(32), .MUL_STEP(4), .DIV_STEP(1)) dut0 (
    .clk_core(clk), .reset_n(reset_n), .bus(bus0.slave), .kill(kill), .busy(bsy[0]));
  muldiv_iter #(.XLEN(32), .MUL_STEP(8), .DIV_STEP(2)) dut1 (
    .clk_core(clk), .reset_n(reset_n), .bus(bus1.slave), .kill(kill), .busy(bsy[1]));
  muldiv_iter #(.XLEN(32), .MUL_STEP(1), .DIV_STEP(2)) dut2 (
    .clk_core(clk), .reset_n(reset_n), .bus(bus2.slave), .kill(kill), .busy(bsy[2]));

  // Architectural reference built on plain SV arithmetic
  function automatic logic [31:0] ref_md(mdop_t o, logic [31:0] x, logic [31:0] y);
    logic [63:0] p;
    logic        ovf;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      OpMul:    begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      OpMulh:   begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; return p[63:32]; end
      OpMulhsu: begin p = {{32{x[31]}}, x} * {32'b0, y}; return p[63:32]; end
      OpMulhu:  begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      OpDiv:    return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y));
      OpDivu:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      OpRem:    return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
      default:  return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int exp_lat(int k, mdop_t o, logic [31:0] x, logic [31:0] y);
    if (o inside {OpDiv, OpDivu, OpRem, OpRemu}) begin
      if (y == 0) return 1;
      if ((o inside {OpDiv, OpRem}) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      return 32 / int'(DS[k]) + 1;
    end
    return 32 / int'(MS[k]) + 1;
  endfunction

  task automatic launch(input mdop_t o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y;
    rv = 3'b111; rr = 3'b000;
    @(posedge clk);
  endtask

  // Wait for each DUT's response, then compare result and accept-to-valid latency
  task automatic collect(input string name, input mdop_t o, input logic [31:0] x,
                         input logic [31:0] y);
    logic [2:0]  done;
    int          lat [3];
    logic [31:0] got [3];
    logic [31:0] exp_r;
    done = 3'b000;
    lat  = '{0, 0, 0};
    got  = '{32'h0, 32'h0, 32'h0};
    exp_r = ref_md(o, x, y);
    for (int c = 0; c < 80 && done != 3'b111; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        if (!done[k]) begin
          lat[k]++;
          if (vld[k]) begin
            done[k] = 1'b1;
            got[k]  = res[k];
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (!done[k] || got[k] !== exp_r) begin
        bad++;
        $display("FAIL %s result dut%0d: got %h (valid=%0b) want %h", name, k, got[k],
                 done[k], exp_r);
      end
      total++;
      if (lat[k] != exp_lat(k, o, x, y)) begin
        bad++;
        $display("FAIL %s latency dut%0d: got %0d want %0d", name, k, lat[k],
                 exp_lat(k, o, x, y));
      end
    end
  endtask

  task automatic retire(input string name);
    @(negedge clk);
    rv = 3'b000; rr = 3'b111;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (vld[k] !== 1'b0 || bsy[k] !== 1'b0) begin
        bad++;
        $display("FAIL %s retire dut%0d: valid=%0b busy=%0b want 0 0", name, k, vld[k], bsy[k]);
      end
    end
    rr = 3'b000;
  endtask

  task automatic do_op(input string name, input mdop_t o, input logic [31:0] x,
                       input logic [31:0] y);
    launch(o, x, y);
    collect(name, o, x, y);
    retire(name);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (vld[k] !== 1'b0 || bsy[k] !== 1'b0 || res[k] !== 32'h0 || rdy[k] !== 1'b1) begin
        bad++;
        $display("FAIL reset dut%0d: valid=%0b busy=%0b result=%h ready=%0b want 0 0 0 1",
                 k, vld[k], bsy[k], res[k], rdy[k]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_mul();
    // operands are scrambled right after accept; the unit must ignore that
    launch(OpMul, 32'd7, 32'hFFFF_FFFD);
    @(negedge clk);
    op = OpDivu; a = 32'h1234_5678; b = 32'h0;
    collect("mul_7x-3", OpMul, 32'd7, 32'hFFFF_FFFD);
    retire("mul_7x-3");
    do_op("mulhu_max", OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulh_min", OpMulh, 32'h8000_0000, 32'h8000_0000);
    do_op("mulhsu_m1", OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_div();
    do_op("div_-7_2", OpDiv, 32'hFFFF_FFF9, 32'd2);
    do_op("rem_-7_2", OpRem, 32'hFFFF_FFF9, 32'd2);
    do_op("divu_100_7", OpDivu, 32'd100, 32'd7);
    do_op("remu_100_7", OpRemu, 32'd100, 32'd7);
  endtask

  task automatic test_special();
    do_op("divu_by0", OpDivu, 32'd5, 32'd0);
    do_op("rem_by0", OpRem, 32'd5, 32'd0);
    do_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_back_to_back();
    launch(OpDivu, 32'd100, 32'd7);
    collect("hold_divu", OpDivu, 32'd100, 32'd7);
    @(negedge clk);
    rv = 3'b000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (vld[k] !== 1'b1 || res[k] !== 32'd14) begin
          bad++;
          $display("FAIL hold dut%0d cycle%0d: valid=%0b result=%h want 1 %h", k, c, vld[k],
                   res[k], 32'd14);
        end
      end
    end
    @(negedge clk);
    op = OpMulhu; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    rv = 3'b111; rr = 3'b111;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (vld[k] !== 1'b0 || bsy[k] !== 1'b1) begin
        bad++;
        $display("FAIL b2b_accept dut%0d: valid=%0b busy=%0b want 0 1", k, vld[k], bsy[k]);
      end
    end
    rr = 3'b000;
    collect("b2b_mulhu", OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    retire("b2b_mulhu");
  endtask

  task automatic test_kill();
    @(negedge clk);
    op = OpMul; a = 32'd3; b = 32'd5;
    rv = 3'b111; kill = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bsy[k] !== 1'b0 || vld[k] !== 1'b0) begin
        bad++;
        $display("FAIL kill_idle dut%0d: busy=%0b valid=%0b want 0 0", k, bsy[k], vld[k]);
      end
    end
    @(negedge clk);
    kill = 1'b0; rv = 3'b000;
    launch(OpDiv, 32'd1000, 32'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bsy[k] !== 1'b0 || vld[k] !== 1'b0) begin
        bad++;
        $display("FAIL kill_div dut%0d: busy=%0b valid=%0b want 0 0", k, bsy[k], vld[k]);
      end
    end
    @(negedge clk);
    kill = 1'b0;
    op = OpMul; a = 32'd12345; b = 32'd678;
    rv = 3'b111;
    @(posedge clk);
    collect("kill_then_mul", OpMul, 32'd12345, 32'd678);
    retire("kill_then_mul");
  endtask

  task automatic test_reset_mid();
    launch(OpMul, 32'd7, 32'hFFFF_FFFD);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0; rv = 3'b000;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (vld[k] !== 1'b0 || bsy[k] !== 1'b0 || res[k] !== 32'h0) begin
        bad++;
        $display("FAIL reset_mid dut%0d: valid=%0b busy=%0b result=%h want 0 0 0", k, vld[k],
                 bsy[k], res[k]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    mdop_t       o;
    logic [31:0] x, y;
    for (int i = 0; i < 16; i++) begin
      o = mdop_t'($urandom_range(0, 7));
      x = $urandom;
      case ($urandom_range(0, 5))
        0:       y = 32'h0;
        1:       y = 32'hFFFF_FFFF;
        2:       y = 32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      if (i == 3) x = 32'h8000_0000;
      do_op("random", o, x, y);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    kill    = 1'b0;
    rv      = 3'b000;
    rr      = 3'b000;
    op      = OpMul;
    a       = 32'h0;
    b       = 32'h0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_kill();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative RV32M multiply/divide unit for the execute stage; next generation of the fixed 4-bit-per-cycle multiplier.
- Adds DIV/DIVU/REM/REMU, a sign-fixup step, RISC-V divide special cases, abort on flush, and a valid/ready handshake that holds the result.
- Bits retired per cycle are parametrised separately for multiply and divide.
- Instantiated in stage_execute:
  - req_valid is driven from ex_valid and the M-extension op.
  - ex_stall includes req_valid & ~resp_valid.
  - kill is driven from ex_br_miss | wb_exc | csr_kill_setpc.

Parameters:
- XLEN, 32, operand/result width; must be a multiple of MUL_STEP and DIV_STEP.
- MUL_STEP, 4, multiplier bits consumed per iteration (1, 2, 4 or 8).
- DIV_STEP, 1, quotient bits produced per iteration (1 or 2).

Ports:
- clk_core  in  1  core clock, all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present; op/a/b stable while high.
- req_ready  out  1  unit can accept a request this cycle.
- req_op  in  mdop_t  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU.
- req_a  in  XLEN  rs1 operand.
- req_b  in  XLEN  rs2 operand.
- kill  in  1  abort the in-flight or just-accepted operation.
- resp_valid  out  1  result valid; held until consumed.
- resp_ready  in  1  consumer takes the result.
- resp_result  out  XLEN  selected result word.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset_n low at an edge, including mid-operation):
  - state goes to IDLE.
  - resp_valid=0, resp_result=0, busy=0.
  - Iteration counter and datapath registers are cleared.
- req_ready = (state==IDLE) | (state==DONE & resp_ready).
- A request is accepted when req_valid & req_ready & ~kill. Operands and op are latched on that edge.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE, on accept:
  - Special case, divide with b==0, goes straight to DONE:
    - DIV/DIVU result = all ones.
    - REM/REMU result = a.
  - Special case, DIV/REM with a==signed min and b==-1, goes straight to DONE:
    - DIV result = a.
    - REM result = 0.
  - Otherwise a multiply op goes to MUL and a divide op goes to DIV.
  - Signed operands are converted to magnitudes on entry. The result-negate flag is recorded:
    - MULH: sign(a)^sign(b).
    - MULHSU: sign(a).
    - DIV: sign(a)^sign(b).
    - REM: sign(a).
- MUL:
  - Each cycle adds multiplicand × (next MUL_STEP multiplier bits) into a 2·XLEN partial product, then shifts.
  - Lasts exactly XLEN/MUL_STEP cycles, then goes to FIX.
- DIV:
  - Restoring division producing DIV_STEP quotient bits per cycle.
  - Lasts exactly XLEN/DIV_STEP cycles, then goes to FIX.
- FIX (one cycle):
  - Negates the 2·XLEN product, quotient or remainder if the negate flag is set.
  - Selects the result word: MUL gives the low word; MULH/MULHSU/MULHU give the high word; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Goes to DONE.
- DONE:
  - resp_valid=1 and resp_result is stable.
  - On resp_ready the unit goes to IDLE, or re-enters MUL/DIV the same cycle if a new request is accepted (back-to-back).
- Latency from accept edge to resp_valid:
  - Multiply: XLEN/MUL_STEP+1 cycles (9 with defaults).
  - Divide: XLEN/DIV_STEP+1 cycles (33 with defaults).
  - Special cases: 1 cycle.
- kill, in any state, has priority over accept and over resp_ready:
  - Next state is IDLE and resp_valid drops next cycle.
  - No response is ever produced for the killed operation.
  - kill while in IDLE with req_valid suppresses the accept.
- req_op, req_a and req_b are ignored after accept; changing them mid-operation has no effect.
- Simulation only: an assertion fires if req_valid falls while in MUL/DIV/FIX without kill.

Decomposition:
- Shared package (the existing defines header):
  - mdop_t enum (8 values, 3 bits).
  - Helper function md_is_div(mdop_t).
  - State enum mdstate_t.
- One natural sub-module, muldiv_divstep: combinational restoring-divide slice for DIV_STEP bits.
  - Inputs: partial remainder, divisor, dividend bits.
  - Outputs: new remainder, quotient bits.
- The multiply step stays inline.

Test Plan:
- MUL 7×(-3), defaults: resp_valid exactly 9 cycles after accept; result 0xFFFFFFEB. MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE.
- MULH 0x80000000×0x80000000 gives 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFF.
- DIV -7/2 gives 0xFFFFFFFD and REM -7/2 gives 0xFFFFFFFF, each at 33 cycles. DIVU 100/7 gives 14 and REMU 100/7 gives 2.
- Divide by zero: DIVU 5/0 gives 0xFFFFFFFF and REM 5/0 gives 5. DIV 0x80000000/-1 gives 0x80000000 and REM gives 0. All special cases respond at 1 cycle.
- kill at cycle 4 of a DIV: IDLE next cycle, no resp_valid. A new MUL accepted the following cycle completes correctly. Reset asserted mid-MUL clears all outputs.
- resp_ready held low for 5 cycles: result held stable. Then resp_ready=1 with a new req_valid the same cycle gives a back-to-back accept. Repeat the whole suite with MUL_STEP=1/8 and DIV_STEP=2, checking latency formulas and random results against a reference model.
